cmplx_sqrt_sched: RTL
=====================

// Module: cmplx_sqrt_sched
// PURPOSE
//  Shares one complex-square-root engine (CORDIC vectoring/rotation pair under its mux controller) among NREQ requesters.
//  Picks one requester round-robin, latches its Q1.15 operand and pulses the engine start.
//  Waits for the engine's one-cycle result valid, then returns the result tagged with the requester id.
//  A watchdog aborts hung jobs and resets the engine.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  IDW       2    id width, = clog2(NREQ)
//  TIMEOUT   255  max cycles from eng_start to eng_valid before abort
//  ABORT_LEN 2    cycles eng_rst is held low on abort
// PORTS
//  clk       in   1        system clock
//  rst       in   1        synchronous active-low reset
//  req       in   NREQ     request per requester; held with data until its gnt bit pulses
//  x_req     in   NREQ*16  signed real operands, requester i at [16i+15:16i]
//  y_req     in   NREQ*16  signed imaginary operands, same packing
//  gnt       out  NREQ     one-hot, one-cycle pulse: operand of that requester accepted
//  eng_start out  1        one-cycle start pulse to engine
//  eng_x     out  16       operand real to engine; held stable for the whole job
//  eng_y     out  16       operand imag to engine; held stable for the whole job
//  eng_rst   out  1        active-low engine reset (1 except during abort)
//  eng_valid in   1        engine result valid (one-cycle pulse)
//  eng_real  in   16       engine result real
//  eng_imag  in   16       engine result imag
//  res_valid out  1        one-cycle result pulse
//  res_id    out  IDW      requester the result belongs to
//  res_real  out  16       result real (0 on error)
//  res_imag  out  16       result imag (0 on error)
//  res_err   out  1        result is a timeout abort
//  busy      out  1        1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0 at a clk edge):
//   - state=IDLE; all outputs 0 except eng_rst=1; round-robin pointer=0.
//   - Mid-job reset drops the job silently; no res_valid is produced.
//  IDLE: if |req, grant the first set bit at or after the pointer (cyclic).
//   - Same cycle: gnt[i]=1, eng_x/eng_y<=operands of i, id<=i, pointer<=(i+1)%NREQ -> LAUNCH.
//  LAUNCH: eng_start=1 for exactly this cycle; watchdog cleared -> WAIT.
//  WAIT: watchdog increments each cycle.
//   - eng_valid -> capture eng_real/eng_imag; next cycle res_valid=1, res_err=0 -> GAP.
//   - watchdog==TIMEOUT with no eng_valid -> res_valid=1, res_err=1, data 0 -> ABORT.
//   - eng_valid has priority if both occur in the same cycle.
//  ABORT: eng_rst=0 for ABORT_LEN cycles -> GAP.
//  GAP: one idle cycle so the engine returns to its idle state -> IDLE.
//   - New requests are not sampled in GAP.
//  Timing and ordering:
//   - Minimum gnt-to-next-gnt spacing = engine latency + 4 cycles.
//   - eng_valid outside WAIT is ignored.
//   - req deasserted before gnt is legal and simply not served.
//   - eng_x/eng_y change only at grant.
//   - res_* fields are held after res_valid until the next result.
//  Arithmetic: pure pass-through, no scaling; watchdog width clog2(TIMEOUT+1); pointer wraps NREQ-1 -> 0.
// STRUCTURE
//  cmplx_sqrt_pkg: state encoding (IDLE, LAUNCH, WAIT, ABORT, GAP), DATA_W=16, Q15 constants, default NREQ/TIMEOUT.
//  Sub-module rr_arbiter (req, ptr -> one-hot grant, grant index); combinational, reused elsewhere.
//  FSM, watchdog, operand/result registers stay in cmplx_sqrt_sched.
// TESTING (bench uses behavioural engine model, latency 20, returns sqrt in Q15)
//  Single request:
//   - req=4'b0100, x=16'h4000, y=0.
//   - gnt=4'b0100 and eng_x=16'h4000 at grant; eng_start on the following cycle.
//   - res_valid with res_id=2, res_real=16'h5A82, res_imag=0, res_err=0.
//  Fairness:
//   - req=4'b1111 held, operands distinct.
//   - Grants in order 0,1,2,3,0; each res_id matches its operand; no overlap.
//  Timeout:
//   - Engine model never asserts valid.
//   - 255 cycles after eng_start: res_valid, res_err=1, data 0.
//   - Then eng_rst low for 2 cycles, then GAP, then next grant possible.
//  Reset mid-job:
//   - rst=0 during WAIT, then an eng_valid arrives.
//   - No res_valid; outputs 0; pointer=0; next req=4'b0001 granted normally.
//  Back-to-back:
//   - Requester 1 re-requests right after its gnt, req=4'b0010 only.
//   - Served again; gnt spacing exactly latency+4 = 24 cycles.
//  Race:
//   - eng_valid in the same cycle the watchdog hits TIMEOUT.
//   - Normal result reported (res_err=0); no abort.

Source files
------------

// File: rtl/cmplx_sqrt_pkg.sv
// Shared types and constants for the complex square-root scheduler.
package cmplx_sqrt_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned DEF_NREQ      = 4;
    localparam int unsigned DEF_IDW       = 2;
    localparam int unsigned DEF_TIMEOUT   = 255;
    localparam int unsigned DEF_ABORT_LEN = 2;

    // Q1.15 constants
    localparam logic [DATA_W-1:0] Q15_ZERO = 16'h0000;
    localparam logic [DATA_W-1:0] Q15_HALF = 16'h4000;

    // Scheduler state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_ABORT  = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    // Complex Q1.15 payload
    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    // True when the value is the Q1.15 half-scale point
    function automatic logic is_q15_half(input logic [DATA_W-1:0] v);
        return v == Q15_HALF;
    endfunction

endpackage

// File: rtl/cmplx_sqrt_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, cyclic.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan requesters starting at ptr and stop at the first hit
    always_comb begin : scan
        int unsigned j;
        logic [IW-1:0] jj;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        jj    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!any && req[jj]) begin
                any       = 1'b1;
                idx       = jj;
                grant[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmplx_sqrt_sched.sv
// Shares one complex square-root engine among NREQ requesters with a watchdog.
module cmplx_sqrt_sched
    import cmplx_sqrt_pkg::*;
#(
    parameter int unsigned NREQ      = DEF_NREQ,
    parameter int unsigned IDW       = DEF_IDW,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter int unsigned ABORT_LEN = DEF_ABORT_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] x_req,
    input  logic [NREQ*DATA_W-1:0] y_req,
    output logic [NREQ-1:0]        gnt,
    output logic                   eng_start,
    output logic [DATA_W-1:0]      eng_x,
    output logic [DATA_W-1:0]      eng_y,
    output logic                   eng_rst,
    input  logic                   eng_valid,
    input  logic [DATA_W-1:0]      eng_real,
    input  logic [DATA_W-1:0]      eng_imag,
    output logic                   res_valid,
    output logic [IDW-1:0]         res_id,
    output logic [DATA_W-1:0]      res_real,
    output logic [DATA_W-1:0]      res_imag,
    output logic                   res_err,
    output logic                   busy
);

    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    localparam int unsigned ACW = $clog2(ABORT_LEN + 1);

    logic [2:0]        state, state_nx;
    logic [IDW-1:0]    ptr, ptr_nx;
    logic [IDW-1:0]    cur_id, id_nx;
    logic [WDW-1:0]    wd, wd_nx;
    logic [ACW-1:0]    ab_cnt, ab_cnt_nx;
    cplx_t             op, op_nx;
    cplx_t             res_q, res_nx;
    logic [IDW-1:0]    res_id_nx;
    logic              res_err_nx;
    logic              res_valid_nx;
    logic [NREQ-1:0]   gnt_nx;
    logic              start_nx;
    logic              eng_rst_nx;
    logic              busy_nx;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDW-1:0]    arb_idx;
    logic              arb_any;

    logic [DATA_W-1:0] x_arr [NREQ];
    logic [DATA_W-1:0] y_arr [NREQ];

    // Unpack the flat operand buses per requester
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign x_arr[g] = x_req[g*DATA_W +: DATA_W];
        assign y_arr[g] = y_req[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_gnt),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign eng_x    = op.re;
    assign eng_y    = op.im;
    assign res_real = res_q.re;
    assign res_imag = res_q.im;

    // Next-state and next-output logic
    always_comb begin : next_logic
        state_nx     = state;
        ptr_nx       = ptr;
        id_nx        = cur_id;
        wd_nx        = wd;
        ab_cnt_nx    = ab_cnt;
        op_nx        = op;
        res_nx       = res_q;
        res_id_nx    = res_id;
        res_err_nx   = res_err;
        res_valid_nx = 1'b0;
        gnt_nx       = '0;
        start_nx     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_nx   = arb_gnt;
                    op_nx.re = x_arr[arb_idx];
                    op_nx.im = y_arr[arb_idx];
                    id_nx    = arb_idx;
                    ptr_nx   = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + IDW'(1);
                    state_nx = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                start_nx = 1'b1;
                wd_nx    = '0;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the timeout cycle still wins
                if (eng_valid) begin
                    res_nx.re    = eng_real;
                    res_nx.im    = eng_imag;
                    res_id_nx    = cur_id;
                    res_err_nx   = 1'b0;
                    res_valid_nx = 1'b1;
                    state_nx     = ST_GAP;
                end else if (wd == WDW'(TIMEOUT)) begin
                    res_nx.re    = Q15_ZERO;
                    res_nx.im    = Q15_ZERO;
                    res_id_nx    = cur_id;
                    res_err_nx   = 1'b1;
                    res_valid_nx = 1'b1;
                    ab_cnt_nx    = '0;
                    state_nx     = ST_ABORT;
                end else begin
                    wd_nx = wd + WDW'(1);
                end
            end
            ST_ABORT: begin
                if (ab_cnt == ACW'(ABORT_LEN - 1)) begin
                    state_nx = ST_GAP;
                end else begin
                    ab_cnt_nx = ab_cnt + ACW'(1);
                end
            end
            ST_GAP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        eng_rst_nx = (state_nx != ST_ABORT);
        busy_nx    = (state_nx != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            cur_id    <= '0;
            wd        <= '0;
            ab_cnt    <= '0;
            op        <= '0;
            res_q     <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
            gnt       <= '0;
            eng_start <= 1'b0;
            eng_rst   <= 1'b1;
            busy      <= 1'b0;
        end else begin
            ptr       <= ptr_nx;
            cur_id    <= id_nx;
            wd        <= wd_nx;
            ab_cnt    <= ab_cnt_nx;
            op        <= op_nx;
            res_q     <= res_nx;
            res_id    <= res_id_nx;
            res_err   <= res_err_nx;
            res_valid <= res_valid_nx;
            gnt       <= gnt_nx;
            eng_start <= start_nx;
            eng_rst   <= eng_rst_nx;
            busy      <= busy_nx;
        end
    end

endmodule
